// File: rtl/mc_sequencer.sv
// Multicycle main controller for the MIPS-subset datapath: one Moore FSM drives every strobe.
// Optional retired-instruction counter enabled by defining MC_RETIRE_COUNT_EN.
module mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_b,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retire_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } stateT;

  stateT curState, nextState;
  logic [CNT_W-1:0] timeoutCnt;

  logic isRType, isAddu, isSubu, isSll, isOri, isLui, isLw, isSw, isBeq, isJ, isJal, legal;
  logic [2:0] decAluOp;
  logic decSrcB, decExt;
  logic memWait, timeoutHit;

  // Instruction decode from the IR fields
  always_comb begin
    isRType  = (op == 6'b000000);
    isAddu   = isRType && (funct == 6'b100001);
    isSubu   = isRType && (funct == 6'b100011);
    isSll    = isRType && (funct == 6'b000000);
    isOri    = (op == 6'b001101);
    isLui    = (op == 6'b001111);
    isLw     = (op == 6'b100011);
    isSw     = (op == 6'b101011);
    isBeq    = (op == 6'b000100);
    isJ      = (op == 6'b000010);
    isJal    = (op == 6'b000011);
    legal    = isAddu || isSubu || isSll || isOri || isLui || isLw || isSw || isBeq || isJ || isJal;
    decAluOp = 3'd0;
    if (isSubu || isBeq) decAluOp = 3'd1;
    else if (isOri)      decAluOp = 3'd2;
    else if (isSll)      decAluOp = 3'd3;
    else if (isLui)      decAluOp = 3'd4;
    decSrcB  = isOri || isLui || isLw || isSw;
    decExt   = isLw || isSw || isBeq;
  end

  assign memWait    = ((curState == S_FETCH) || (curState == S_MEM)) && !mem_ready;
  assign timeoutHit = memWait && (timeoutCnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curState <= S_FETCH;
    else        curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    case (curState)
      S_FETCH: begin
        if (mem_ready)       nextState = S_DECODE;
        else if (timeoutHit) nextState = S_TRAP;
      end
      S_DECODE: begin
        if (!legal)              nextState = S_TRAP;
        else if (isJ || isJal)   nextState = S_FETCH;
        else                     nextState = S_EXEC;
      end
      S_EXEC: begin
        if (isBeq)             nextState = S_FETCH;
        else if (isLw || isSw) nextState = S_MEM;
        else                   nextState = S_WB;
      end
      S_MEM: begin
        if (mem_ready)       nextState = isSw ? S_FETCH : S_WB;
        else if (timeoutHit) nextState = S_TRAP;
      end
      S_WB:    nextState = S_FETCH;
      S_TRAP:  nextState = S_TRAP;
      default: nextState = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so nothing leaks during reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_b  = 1'b0;
    ext_op     = 1'b0;
    alu_op     = 3'd0;
    if (reset) begin
      if (curState != S_TRAP) begin
        alu_op    = decAluOp;
        alu_src_b = decSrcB;
        ext_op    = decExt;
      end
      case (curState)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          if (isJ || isJal) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
          if (isJal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
        S_EXEC: begin
          if (isBeq) begin
            pc_src   = 2'd1;
            pc_write = zero;
          end
        end
        S_MEM: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_write = isSw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = isRType ? 2'd1 : 2'd0;
          mem_to_reg = isLw ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  // Wait counter restarts on every state change; traps are sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeoutCnt <= '0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if (nextState != curState) timeoutCnt <= '0;
      else if (memWait)          timeoutCnt <= timeoutCnt + CNT_W'(1);
      if ((curState == S_DECODE) && !legal) illegal <= 1'b1;
      if (timeoutHit) bus_err <= 1'b1;
    end
  end

  assign state = curState;

`ifdef MC_RETIRE_COUNT_EN
  logic [31:0] retireQ;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retireQ <= '0;
    else if ((nextState == S_FETCH) &&
             ((curState == S_DECODE) || (curState == S_EXEC) ||
              (curState == S_MEM) || (curState == S_WB)))
      retireQ <= retireQ + 32'd1;
  end
  assign retire_cnt = retireQ;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed self-checking bench for mc_sequencer (built with MEM_TIMEOUT=4).
`timescale 1ns/1ps
module tb_mc_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, funct;
  logic zero, mem_ready;
  logic mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, alu_src_b, ext_op;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_op, state;
  logic illegal, bus_err;
  logic [31:0] retire_cnt;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;
  logic [31:0] expRetire = 32'd0;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .state(state), .illegal(illegal), .bus_err(bus_err), .retire_cnt(retire_cnt)
  );

  assign obs = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_write,
                reg_dst, mem_to_reg, alu_src_b, ext_op, alu_op};

  function automatic logic [16:0] pk(input logic mr, input logic mw, input logic iod,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] mtr,
                                     input logic asb, input logic eo, input logic [2:0] ao);
    return {mr, mw, iod, irw, pcw, pcs, rw, rd, mtr, asb, eo, ao};
  endfunction

  task automatic bump_retire;
`ifdef MC_RETIRE_COUNT_EN
    expRetire = expRetire + 32'd1;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b0; op = 6'd0; funct = 6'h21; zero = 1'b0; mem_ready = 1'b1;
    #2;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
    checks++; if (obs !== 17'h0) begin errors++; $display("FAIL reset_strobes got %h expected 0", obs); end
    checks++; if ({illegal, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_traps got %b expected 00", {illegal, bus_err}); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d expected 0", retire_cnt); end
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_addu;
    logic [2:0] st [5];
    logic [16:0] ob [5];
    op = 6'h00; funct = 6'h21; mem_ready = 1'b1;
    st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    ob = '{pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0,3'd0), 17'h0, 17'h0,
           pk(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,0,3'd0), pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0,3'd0)};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL addu_state cyc%0d got %0d expected %0d", i, state, st[i]); end
      checks++; if (obs !== ob[i]) begin errors++; $display("FAIL addu_strobes cyc%0d got %h expected %h", i, obs, ob[i]); end
      if (i < 4) begin @(posedge clk); #1; end
    end
    bump_retire();
    checks++; if (retire_cnt !== expRetire) begin errors++; $display("FAIL addu_retire got %0d expected %0d", retire_cnt, expRetire); end
  endtask

  task automatic test_lw_wait;
    logic [2:0] st [8];
    logic rdy [8];
    logic [16:0] ob [8];
    logic [16:0] memOb, decOb, fetOb;
    op = 6'h23; funct = 6'h00;
    fetOb = pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,1,1,3'd0);
    decOb = pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,1,3'd0);
    memOb = pk(1,0,1,0,0,2'd0,0,2'd0,2'd0,1,1,3'd0);
    st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ob  = '{fetOb, decOb, decOb, memOb, memOb, memOb,
            pk(0,0,0,0,0,2'd0,1,2'd0,2'd1,1,1,3'd0), fetOb};
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL lw_state cyc%0d got %0d expected %0d", i, state, st[i]); end
      checks++; if (obs !== ob[i]) begin errors++; $display("FAIL lw_strobes cyc%0d got %h expected %h", i, obs, ob[i]); end
      if (i < 7) begin @(posedge clk); #1; end
    end
    bump_retire();
  endtask

  task automatic test_beq;
    logic [2:0] st [4];
    logic [16:0] ob [4];
    op = 6'h04; funct = 6'h00; mem_ready = 1'b1;
    st = '{3'd0, 3'd1, 3'd2, 3'd0};
    for (int pass = 0; pass < 2; pass++) begin
      zero = (pass == 0);
      ob = '{pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,1,3'd1), pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1,3'd1),
             pk(0,0,0,0,(pass == 0),2'd1,0,2'd0,2'd0,0,1,3'd1), pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,1,3'd1)};
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++; if (state !== st[i]) begin errors++; $display("FAIL beq%0d_state cyc%0d got %0d expected %0d", pass, i, state, st[i]); end
        checks++; if (obs !== ob[i]) begin errors++; $display("FAIL beq%0d_strobes cyc%0d got %h expected %h", pass, i, obs, ob[i]); end
        if (i < 3) begin @(posedge clk); #1; end
      end
      bump_retire();
    end
    zero = 1'b0;
  endtask

  task automatic test_jal;
    logic [2:0] st [3];
    logic [16:0] ob [3];
    op = 6'h03; funct = 6'h00; mem_ready = 1'b1;
    st = '{3'd0, 3'd1, 3'd0};
    ob = '{pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0,3'd0), pk(0,0,0,0,1,2'd2,1,2'd2,2'd2,0,0,3'd0),
           pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0,3'd0)};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL jal_state cyc%0d got %0d expected %0d", i, state, st[i]); end
      checks++; if (obs !== ob[i]) begin errors++; $display("FAIL jal_strobes cyc%0d got %h expected %h", i, obs, ob[i]); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    bump_retire();
    checks++; if (retire_cnt !== expRetire) begin errors++; $display("FAIL jal_retire got %0d expected %0d", retire_cnt, expRetire); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] st [5];
    logic [16:0] ob [5];
    op = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
    st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    ob = '{pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,1,1,3'd0), pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,1,3'd0),
           pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,1,3'd0), pk(1,1,1,0,0,2'd0,0,2'd0,2'd0,1,1,3'd0),
           pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,1,1,3'd0)};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL sw_state cyc%0d got %0d expected %0d", i, state, st[i]); end
      checks++; if (obs !== ob[i]) begin errors++; $display("FAIL sw_strobes cyc%0d got %h expected %h", i, obs, ob[i]); end
      if (i < 4) begin @(posedge clk); #1; end
    end
    bump_retire();
    op = 6'h02;
    @(posedge clk); #1;
    checks++; if (obs !== pk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,0,3'd0)) begin errors++; $display("FAIL j_decode got %h expected %h", obs, pk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,0,3'd0)); end
    @(posedge clk); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL j_return got %0d expected 0", state); end
    bump_retire();
    checks++; if (retire_cnt !== expRetire) begin errors++; $display("FAIL b2b_retire got %0d expected %0d", retire_cnt, expRetire); end
  endtask

  task automatic test_alu_decode;
    logic [5:0] ops [4];
    logic [5:0] fns [4];
    logic [2:0] aop [4];
    logic src [4];
    logic [1:0] rdst [4];
    logic [16:0] e;
    ops = '{6'h00, 6'h00, 6'h0d, 6'h0f};
    fns = '{6'h23, 6'h00, 6'h00, 6'h00};
    aop = '{3'd1, 3'd3, 3'd2, 3'd4};
    src = '{1'b0, 1'b0, 1'b1, 1'b1};
    rdst = '{2'd1, 2'd1, 2'd0, 2'd0};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = ops[k]; funct = fns[k];
      @(posedge clk); #1;
      @(posedge clk); #1;
      e = pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,src[k],0,aop[k]);
      checks++; if (obs !== e) begin errors++; $display("FAIL alu%0d_exec got %h expected %h", k, obs, e); end
      @(posedge clk); #1;
      e = pk(0,0,0,0,0,2'd0,1,rdst[k],2'd0,src[k],0,aop[k]);
      checks++; if (obs !== e) begin errors++; $display("FAIL alu%0d_wb got %h expected %h", k, obs, e); end
      @(posedge clk); #1;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL alu%0d_return got %0d expected 0", k, state); end
      bump_retire();
    end
    checks++; if (retire_cnt !== expRetire) begin errors++; $display("FAIL alu_retire got %0d expected %0d", retire_cnt, expRetire); end
  endtask

  task automatic test_reset_mid;
    op = 6'h00; funct = 6'h21; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL mid_wb_write got %b expected 1", reg_write); end
    #1; reset = 1'b0; #1;
    checks++; if (obs !== 17'h0) begin errors++; $display("FAIL mid_reset_strobes got %h expected 0", obs); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_reset_state got %0d expected 0", state); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL mid_reset_retire got %0d expected 0", retire_cnt); end
    expRetire = 32'd0;
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_illegal;
    op = 6'h3f; funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (obs !== 17'h0) begin errors++; $display("FAIL ill_decode_strobes got %h expected 0", obs); end
    @(posedge clk); #1;
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL ill_state got %0d expected 7", state); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b expected 1", illegal); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if ({state, obs, illegal} !== {3'd7, 17'h0, 1'b1}) begin errors++; $display("FAIL ill_hold cyc%0d state %0d strobes %h illegal %b expected 7/0/1", i, state, obs, illegal); end
    end
    reset = 1'b0; #1;
    checks++; if ({state, obs, illegal} !== {3'd0, 17'h0, 1'b0}) begin errors++; $display("FAIL ill_reset state %0d strobes %h illegal %b expected 0/0/0", state, obs, illegal); end
    @(posedge clk); #1; reset = 1'b1;
    op = 6'h00; funct = 6'h3f;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({state, illegal} !== {3'd7, 1'b1}) begin errors++; $display("FAIL ill_funct state %0d illegal %b expected 7/1", state, illegal); end
    reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    expRetire = 32'd0;
  endtask

  task automatic test_timeout;
    logic [16:0] waitOb;
    op = 6'h00; funct = 6'h21; mem_ready = 1'b0;
    waitOb = pk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({state, obs} !== {3'd0, waitOb}) begin errors++; $display("FAIL to_wait cyc%0d state %0d strobes %h expected 0/%h", i, state, obs, waitOb); end
      @(posedge clk); #1;
    end
    checks++; if ({state, bus_err, obs} !== {3'd7, 1'b1, 17'h0}) begin errors++; $display("FAIL to_trap state %0d bus_err %b strobes %h expected 7/1/0", state, bus_err, obs); end
    reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    mem_ready = 1'b1; #1;
    checks++; if ({state, ir_write, pc_write} !== {3'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL to_late_ready state %0d ir %b pc %b expected 0/1/1", state, ir_write, pc_write); end
    @(posedge clk); #1;
    checks++; if ({state, bus_err} !== {3'd1, 1'b0}) begin errors++; $display("FAIL to_decode state %0d bus_err %b expected 1/0", state, bus_err); end
    repeat (3) begin @(posedge clk); #1; end
    bump_retire();
    checks++; if ({state, retire_cnt} !== {3'd0, expRetire}) begin errors++; $display("FAIL to_finish state %0d retire %0d expected 0/%0d", state, retire_cnt, expRetire); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_back_to_back();
    test_alu_decode();
    test_reset_mid();
    test_illegal();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
